// File: rtl/spu_pkg.sv
// Shared types and constants for the odd-pipe issue stage.
package spu_pkg;

  localparam int SPU_DATA_W   = 128;
  localparam int SPU_ADDR_W   = 7;
  localparam int SPU_FW_DEPTH = 7;
  localparam int SPU_PC_W     = 8;
  localparam int SPU_OP_W     = 11;
  localparam int SPU_FMT_W    = 3;
  localparam int SPU_UNIT_W   = 2;
  localparam int SPU_IMM_W    = 18;

  localparam logic [SPU_UNIT_W-1:0] UNIT_PERM = 2'd0;
  localparam logic [SPU_UNIT_W-1:0] UNIT_LS   = 2'd1;
  localparam logic [SPU_UNIT_W-1:0] UNIT_BR   = 2'd2;
  localparam logic [SPU_UNIT_W-1:0] UNIT_NONE = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Everything presented to the odd pipe on one issue slot.
  typedef struct packed {
    logic [SPU_OP_W-1:0]   op;
    logic [SPU_FMT_W-1:0]  format;
    logic [SPU_UNIT_W-1:0] unit;
    logic [SPU_ADDR_W-1:0] rt_addr;
    logic [SPU_DATA_W-1:0] ra;
    logic [SPU_DATA_W-1:0] rb;
    logic [SPU_DATA_W-1:0] rt_st;
    logic [SPU_IMM_W-1:0]  imm;
    logic                  reg_write;
    logic [SPU_PC_W-1:0]   pc_in;
    logic                  first;
  } issue_t;

  // Decoded instruction as kept while waiting out a hazard.
  typedef struct packed {
    logic [SPU_OP_W-1:0]   op;
    logic [SPU_FMT_W-1:0]  format;
    logic [SPU_UNIT_W-1:0] unit;
    logic [SPU_ADDR_W-1:0] rt_addr;
    logic [SPU_ADDR_W-1:0] ra_addr;
    logic [SPU_ADDR_W-1:0] rb_addr;
    logic [SPU_ADDR_W-1:0] rc_addr;
    logic                  use_ra;
    logic                  use_rb;
    logic                  use_rc;
    logic [SPU_IMM_W-1:0]  imm;
    logic                  reg_write;
    logic [SPU_PC_W-1:0]   pc;
    logic                  first;
  } hold_t;

  // A bubble: no unit, no writeback, all data zero.
  function automatic issue_t bubble_issue();
    issue_t b;
    b      = '0;
    b.unit = UNIT_NONE;
    return b;
  endfunction

  // Sixteen-bit counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// One source operand: youngest forwarding entry, then writeback, then register file.
module operand_fwd_mux #(
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 7,
  parameter int FW_DEPTH = 7
) (
  input  logic                               i_use,
  input  logic [ADDR_W-1:0]                  i_addr,
  input  logic [FW_DEPTH-1:0][DATA_W-1:0]    i_fw_data,
  input  logic [FW_DEPTH-1:0][ADDR_W-1:0]    i_fw_addr,
  input  logic [FW_DEPTH-1:0]                i_fw_write,
  input  logic [DATA_W-1:0]                  i_wb_data,
  input  logic [ADDR_W-1:0]                  i_wb_addr,
  input  logic                               i_wb_write,
  input  logic [DATA_W-1:0]                  i_rf_data,
  output logic [DATA_W-1:0]                  o_data
);

  // Entry 0 of the staging array never forwards.
  logic w_unused;
  assign w_unused = ^{i_fw_data[0], i_fw_addr[0], i_fw_write[0]};

  // Priority select; scanning high to low lets the lowest matching index win.
  always_comb begin
    o_data = '0;
    if (i_use) begin
      if (i_wb_write && (i_wb_addr == i_addr)) begin
        o_data = i_wb_data;
      end else begin
        o_data = i_rf_data;
      end
      for (int i = FW_DEPTH - 1; i >= 1; i--) begin
        if (i_fw_write[i] && (i_fw_addr[i] == i_addr)) begin
          o_data = i_fw_data[i];
        end else begin
          o_data = o_data;
        end
      end
    end else begin
      o_data = '0;
    end
  end

endmodule

// File: rtl/odd_issue_stage.sv
// Register-fetch / forward / hazard-stall stage issuing to the odd pipe.
module odd_issue_stage
  import spu_pkg::*;
#(
  parameter int DATA_W   = SPU_DATA_W,
  parameter int ADDR_W   = SPU_ADDR_W,
  parameter int FW_DEPTH = SPU_FW_DEPTH,
  parameter int PC_W     = SPU_PC_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [10:0]                     in_op,
  input  logic [2:0]                      in_format,
  input  logic [1:0]                      in_unit,
  input  logic [ADDR_W-1:0]               in_rt_addr,
  input  logic [ADDR_W-1:0]               in_ra_addr,
  input  logic [ADDR_W-1:0]               in_rb_addr,
  input  logic [ADDR_W-1:0]               in_rc_addr,
  input  logic                            in_use_ra,
  input  logic                            in_use_rb,
  input  logic                            in_use_rc,
  input  logic [17:0]                     in_imm,
  input  logic                            in_reg_write,
  input  logic [PC_W-1:0]                 in_pc,
  input  logic                            in_first,
  output logic [ADDR_W-1:0]               rf_ra_addr,
  output logic [ADDR_W-1:0]               rf_rb_addr,
  output logic [ADDR_W-1:0]               rf_rc_addr,
  input  logic [DATA_W-1:0]               rf_ra,
  input  logic [DATA_W-1:0]               rf_rb,
  input  logic [DATA_W-1:0]               rf_rc,
  input  logic [FW_DEPTH-1:0][DATA_W-1:0] fw_wb,
  input  logic [FW_DEPTH-1:0][ADDR_W-1:0] fw_addr_wb,
  input  logic [FW_DEPTH-1:0]             fw_write_wb,
  input  logic [DATA_W-1:0]               rt_wb,
  input  logic [ADDR_W-1:0]               rt_addr_wb,
  input  logic                            reg_write_wb,
  input  logic [FW_DEPTH-1:0][ADDR_W-1:0] rt_addr_delay,
  input  logic [FW_DEPTH-1:0]             reg_write_delay,
  input  logic                            flush,
  output logic [10:0]                     op,
  output logic [2:0]                      format,
  output logic [1:0]                      unit,
  output logic [ADDR_W-1:0]               rt_addr,
  output logic [DATA_W-1:0]               ra,
  output logic [DATA_W-1:0]               rb,
  output logic [DATA_W-1:0]               rt_st,
  output logic [17:0]                     imm,
  output logic                            reg_write,
  output logic [PC_W-1:0]                 pc_in,
  output logic                            first,
  output logic                            out_valid,
  output logic [15:0]                     stall_cnt
);

  state_t      r_state;
  hold_t       r_hold;
  issue_t      r_issue;
  logic        r_out_valid;
  logic [15:0] r_stall_cnt;

  hold_t       w_cand;
  logic        w_hazard;
  logic [DATA_W-1:0] w_ra;
  logic [DATA_W-1:0] w_rb;
  logic [DATA_W-1:0] w_rc;
  issue_t      w_issue;

  // Scoreboard entry 0 is never consulted.
  logic w_unused;
  assign w_unused = ^{rt_addr_delay[0], reg_write_delay[0]};

  // Candidate is the held instruction in HOLD, otherwise the incoming one.
  always_comb begin
    w_cand = '0;
    if (r_state == ST_HOLD) begin
      w_cand = r_hold;
    end else begin
      w_cand.op        = in_op;
      w_cand.format    = in_format;
      w_cand.unit      = in_unit;
      w_cand.rt_addr   = in_rt_addr;
      w_cand.ra_addr   = in_ra_addr;
      w_cand.rb_addr   = in_rb_addr;
      w_cand.rc_addr   = in_rc_addr;
      w_cand.use_ra    = in_use_ra;
      w_cand.use_rb    = in_use_rb;
      w_cand.use_rc    = in_use_rc;
      w_cand.imm       = in_imm;
      w_cand.reg_write = in_reg_write;
      w_cand.pc        = in_pc;
      w_cand.first     = in_first;
    end
  end

  assign rf_ra_addr = w_cand.ra_addr;
  assign rf_rb_addr = w_cand.rb_addr;
  assign rf_rc_addr = w_cand.rc_addr;
  assign in_ready   = (r_state == ST_IDLE);

  // RAW hazard: any used source matching a live in-flight destination (entries 1..N-1).
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 1; i < FW_DEPTH; i++) begin
      if (reg_write_delay[i] &&
          ((w_cand.use_ra && (rt_addr_delay[i] == w_cand.ra_addr)) ||
           (w_cand.use_rb && (rt_addr_delay[i] == w_cand.rb_addr)) ||
           (w_cand.use_rc && (rt_addr_delay[i] == w_cand.rc_addr)))) begin
        w_hazard = 1'b1;
      end else begin
        w_hazard = w_hazard;
      end
    end
  end

  operand_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FW_DEPTH(FW_DEPTH)) u_mux_ra (
    .i_use(w_cand.use_ra), .i_addr(w_cand.ra_addr),
    .i_fw_data(fw_wb), .i_fw_addr(fw_addr_wb), .i_fw_write(fw_write_wb),
    .i_wb_data(rt_wb), .i_wb_addr(rt_addr_wb), .i_wb_write(reg_write_wb),
    .i_rf_data(rf_ra), .o_data(w_ra)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FW_DEPTH(FW_DEPTH)) u_mux_rb (
    .i_use(w_cand.use_rb), .i_addr(w_cand.rb_addr),
    .i_fw_data(fw_wb), .i_fw_addr(fw_addr_wb), .i_fw_write(fw_write_wb),
    .i_wb_data(rt_wb), .i_wb_addr(rt_addr_wb), .i_wb_write(reg_write_wb),
    .i_rf_data(rf_rb), .o_data(w_rb)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FW_DEPTH(FW_DEPTH)) u_mux_rc (
    .i_use(w_cand.use_rc), .i_addr(w_cand.rc_addr),
    .i_fw_data(fw_wb), .i_fw_addr(fw_addr_wb), .i_fw_write(fw_write_wb),
    .i_wb_data(rt_wb), .i_wb_addr(rt_addr_wb), .i_wb_write(reg_write_wb),
    .i_rf_data(rf_rc), .o_data(w_rc)
  );

  // Issue bundle built from the candidate and its selected operands.
  always_comb begin
    w_issue           = '0;
    w_issue.op        = w_cand.op;
    w_issue.format    = w_cand.format;
    w_issue.unit      = w_cand.unit;
    w_issue.rt_addr   = w_cand.rt_addr;
    w_issue.ra        = w_ra;
    w_issue.rb        = w_rb;
    w_issue.rt_st     = w_rc;
    w_issue.imm       = w_cand.imm;
    w_issue.reg_write = w_cand.reg_write;
    w_issue.pc_in     = w_cand.pc;
    w_issue.first     = w_cand.first;
  end

  // Issue FSM: flush first, then issue / capture / stall, with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_issue     <= bubble_issue();
      r_out_valid <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_issue     <= bubble_issue();
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && !w_hazard) begin
            r_issue     <= w_issue;
            r_out_valid <= 1'b1;
          end else if (in_valid) begin
            r_hold      <= w_cand;
            r_issue     <= bubble_issue();
            r_out_valid <= 1'b0;
            r_stall_cnt <= sat_inc16(r_stall_cnt);
            r_state     <= ST_HOLD;
          end else begin
            r_issue     <= bubble_issue();
            r_out_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (w_hazard) begin
            r_issue     <= bubble_issue();
            r_out_valid <= 1'b0;
            r_stall_cnt <= sat_inc16(r_stall_cnt);
          end else begin
            r_issue     <= w_issue;
            r_out_valid <= 1'b1;
            r_hold      <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_hold      <= '0;
          r_issue     <= bubble_issue();
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign op        = r_issue.op;
  assign format    = r_issue.format;
  assign unit      = r_issue.unit;
  assign rt_addr   = r_issue.rt_addr;
  assign ra        = r_issue.ra;
  assign rb        = r_issue.rb;
  assign rt_st     = r_issue.rt_st;
  assign imm       = r_issue.imm;
  assign reg_write = r_issue.reg_write;
  assign pc_in     = r_issue.pc_in;
  assign first     = r_issue.first;
  assign out_valid = r_out_valid;
  assign stall_cnt = r_stall_cnt;

endmodule
